// File: rtl/inst_fetch_if.sv
// Bundle of the fetch-stage signals: nextpc_gen handshake, instruction SRAM port,
// flush input and the IF/ID boundary register outputs.
interface inst_fetch_if;
    logic        pc_refresh;
    logic [31:0] pc;
    logic        pc_adel;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_allowin;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_adel;

    modport master (
        input  pc, pc_adel, flush, inst_addr_ok, inst_data_ok, inst_rdata, id_allowin,
        output pc_refresh, inst_req, inst_addr, if_valid, if_inst, if_pc, if_adel
    );

    modport slave (
        output pc, pc_adel, flush, inst_addr_ok, inst_data_ok, inst_rdata, id_allowin,
        input  pc_refresh, inst_req, inst_addr, if_valid, if_inst, if_pc, if_adel
    );
endinterface

// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: one outstanding SRAM request, a one-entry skid
// register and cancellation of responses that were in flight across a flush.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_CANCEL
    } state_t;

    state_t      state_q;
    logic [31:0] req_pc_q;
    logic [31:0] skid_inst_q;
    logic [31:0] skid_pc_q;
    logic        if_valid_q;
    logic [31:0] if_inst_q;
    logic [31:0] if_pc_q;
    logic        if_adel_q;

    logic        slot_free;
    logic        pop;
    logic        req_go;
    logic        adel_load;
    logic        req_fire;

    // rst gates the strobes so nothing leaks out while the state is being forced.
    always_comb begin
        slot_free = !if_valid_q || bus.id_allowin;
        pop       = if_valid_q && bus.id_allowin;
        req_go    = rst && (state_q == S_REQ) && slot_free && !bus.flush;
        adel_load = req_go && bus.pc_adel;
        req_fire  = req_go && !bus.pc_adel && bus.inst_addr_ok;
    end

    assign bus.inst_req   = req_go && !bus.pc_adel;
    assign bus.inst_addr  = bus.pc;
    assign bus.pc_refresh = rst && (req_fire || adel_load || bus.flush);

    assign bus.if_valid   = if_valid_q;
    assign bus.if_inst    = if_inst_q;
    assign bus.if_pc      = if_pc_q;
    assign bus.if_adel    = if_adel_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_REQ;
            req_pc_q    <= RESET_PC;
            skid_inst_q <= 32'h0;
            skid_pc_q   <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_inst_q   <= 32'h0;
            if_pc_q     <= RESET_PC;
            if_adel_q   <= 1'b0;
        end else if (bus.flush) begin
            // Flush wins over everything; an in-flight response still has to be absorbed.
            if_valid_q  <= 1'b0;
            skid_inst_q <= 32'h0;
            skid_pc_q   <= RESET_PC;
            unique case (state_q)
                S_WAIT, S_CANCEL: state_q <= bus.inst_data_ok ? S_REQ : S_CANCEL;
                default:          state_q <= S_REQ;
            endcase
        end else begin
            if (pop) begin
                if_valid_q <= 1'b0;
            end
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc_q <= bus.pc;
                        state_q  <= S_WAIT;
                    end else if (adel_load) begin
                        // Faulting PC bypasses the SRAM and travels down as a tagged bubble.
                        if_valid_q <= 1'b1;
                        if_inst_q  <= 32'h0;
                        if_pc_q    <= bus.pc;
                        if_adel_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.inst_data_ok) begin
                        if (slot_free) begin
                            if_valid_q <= 1'b1;
                            if_inst_q  <= bus.inst_rdata;
                            if_pc_q    <= req_pc_q;
                            if_adel_q  <= 1'b0;
                            state_q    <= S_REQ;
                        end else begin
                            skid_inst_q <= bus.inst_rdata;
                            skid_pc_q   <= req_pc_q;
                            state_q     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.id_allowin) begin
                        if_valid_q <= 1'b1;
                        if_inst_q  <= skid_inst_q;
                        if_pc_q    <= skid_pc_q;
                        if_adel_q  <= 1'b0;
                        state_q    <= S_REQ;
                    end
                end
                S_CANCEL: begin
                    if (bus.inst_data_ok) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios, then a randomized SRAM / nextpc / decode
// environment whose expected instruction stream is kept in a scoreboard queue.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] EXC_PC   = 32'hbfc00380;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   npop   = 0;
    exp_t sb[$];
    bit   sb_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Monitor: every instruction accepted by decode must be the next expected one.
    exp_t        mon_e;
    bit          stall_prev = 1'b0;
    bit          flush_prev = 1'b0;
    logic [31:0] stall_pc, stall_inst;
    always @(negedge clk) begin
        if (sb_en && rst) begin
            if (bus.if_valid && bus.id_allowin) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual pc=%h required=no output t=%0t", bus.if_pc, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_pc", bus.if_pc, mon_e.pc);
                    chk("out_inst", bus.if_inst, mon_e.inst);
                    chk("out_adel", {31'b0, bus.if_adel}, {31'b0, mon_e.adel});
                    npop++;
                end
            end
            if (stall_prev && !flush_prev) begin
                chk("stall_valid", {31'b0, bus.if_valid}, 32'd1);
                chk("stall_pc", bus.if_pc, stall_pc);
                chk("stall_inst", bus.if_inst, stall_inst);
            end
            stall_prev = bus.if_valid && !bus.id_allowin;
            stall_pc   = bus.if_pc;
            stall_inst = bus.if_inst;
            flush_prev = bus.flush;
        end
    end

    logic [31:0] pc_r;
    bit          refresh_seen, flush_seen, env_out, issue, fake, busy;
    logic [31:0] env_addr;
    int          env_lat;

    initial begin
        bus.pc           = RESET_PC;
        bus.pc_adel      = 1'b0;
        bus.flush        = 1'b1;
        bus.inst_addr_ok = 1'b1;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        bus.id_allowin   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_req", {31'b0, bus.inst_req}, 32'd0);
        chk("rst_refresh", {31'b0, bus.pc_refresh}, 32'd0);
        chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("rst_if_inst", bus.if_inst, 32'h0);
        chk("rst_if_pc", bus.if_pc, RESET_PC);
        chk("rst_if_adel", {31'b0, bus.if_adel}, 32'd0);

        // Basic fetch
        @(posedge clk); #1;
        rst = 1'b1; bus.flush = 1'b0; bus.inst_addr_ok = 1'b1;
        @(negedge clk);
        chk("basic_req_c1", {31'b0, bus.inst_req}, 32'd1);
        chk("basic_refresh_c1", {31'b0, bus.pc_refresh}, 32'd1);
        chk("basic_addr_c1", bus.inst_addr, RESET_PC);
        @(posedge clk); #1;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h24010001;
        bus.pc = 32'hbfc00004;
        @(negedge clk);
        chk("basic_wait_noreq", {31'b0, bus.inst_req}, 32'd0);
        chk("basic_valid_c2", {31'b0, bus.if_valid}, 32'd0);
        @(posedge clk); #1;
        bus.inst_data_ok = 1'b0;
        @(negedge clk);
        chk("basic_valid_c3", {31'b0, bus.if_valid}, 32'd1);
        chk("basic_pc_c3", bus.if_pc, RESET_PC);
        chk("basic_inst_c3", bus.if_inst, 32'h24010001);
        chk("basic_req_c3", {31'b0, bus.inst_req}, 32'd1);

        // Stall: output held, no request while the slot is busy
        @(posedge clk); #1;
        bus.inst_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h8c220004;
        bus.pc = 32'hbfc00008;
        @(posedge clk); #1;
        bus.inst_data_ok = 1'b0; bus.id_allowin = 1'b0; bus.inst_addr_ok = 1'b1;
        @(negedge clk);
        chk("stall_noreq", {31'b0, bus.inst_req}, 32'd0);
        chk("stall_norefresh", {31'b0, bus.pc_refresh}, 32'd0);
        chk("stall_hold_pc", bus.if_pc, 32'hbfc00004);
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("stall_hold_inst", bus.if_inst, 32'h8c220004);
            chk("stall_hold_noreq", {31'b0, bus.inst_req}, 32'd0);
        end
        @(posedge clk); #1;
        bus.id_allowin = 1'b1;
        @(negedge clk);
        chk("release_req", {31'b0, bus.inst_req}, 32'd1);
        chk("release_refresh", {31'b0, bus.pc_refresh}, 32'd1);
        @(posedge clk); #1;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h3c1dbfc0;
        bus.pc = 32'hbfc0000c;
        @(negedge clk);
        chk("release_popped", {31'b0, bus.if_valid}, 32'd0);
        @(posedge clk); #1;
        bus.inst_data_ok = 1'b0;
        @(negedge clk);
        chk("release_next_pc", bus.if_pc, 32'hbfc00008);
        chk("release_next_inst", bus.if_inst, 32'h3c1dbfc0);

        // Address error: pop and fake load in the same cycle
        @(posedge clk); #1;
        bus.pc = 32'hbfc00002; bus.pc_adel = 1'b1; bus.inst_addr_ok = 1'b1;
        @(negedge clk);
        chk("adel_noreq", {31'b0, bus.inst_req}, 32'd0);
        chk("adel_refresh", {31'b0, bus.pc_refresh}, 32'd1);
        @(posedge clk); #1;
        bus.pc = 32'hbfc00010; bus.pc_adel = 1'b0; bus.inst_addr_ok = 1'b0;
        @(negedge clk);
        chk("adel_valid", {31'b0, bus.if_valid}, 32'd1);
        chk("adel_flag", {31'b0, bus.if_adel}, 32'd1);
        chk("adel_inst", bus.if_inst, 32'h0);
        chk("adel_pc", bus.if_pc, 32'hbfc00002);

        // Flush while a request is in flight
        @(posedge clk); #1;
        bus.inst_addr_ok = 1'b1;
        @(negedge clk);
        chk("fl_req", {31'b0, bus.inst_req}, 32'd1);
        @(posedge clk); #1;
        bus.inst_addr_ok = 1'b0; bus.flush = 1'b1; bus.pc = 32'hbfc00014;
        @(negedge clk);
        chk("fl_refresh", {31'b0, bus.pc_refresh}, 32'd1);
        chk("fl_noreq", {31'b0, bus.inst_req}, 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.pc = EXC_PC;
        @(negedge clk);
        chk("fl_cleared", {31'b0, bus.if_valid}, 32'd0);
        chk("fl_cancel_noreq", {31'b0, bus.inst_req}, 32'd0);
        @(posedge clk); #1;
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hdeadbeef;
        @(negedge clk);
        chk("fl_drop_noreq", {31'b0, bus.inst_req}, 32'd0);
        @(posedge clk); #1;
        bus.inst_data_ok = 1'b0; bus.inst_addr_ok = 1'b1;
        @(negedge clk);
        chk("fl_dropped", {31'b0, bus.if_valid}, 32'd0);
        chk("fl_new_req", {31'b0, bus.inst_req}, 32'd1);
        chk("fl_new_addr", bus.inst_addr, EXC_PC);
        @(posedge clk); #1;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h42000018;
        bus.pc = EXC_PC + 32'd4;
        @(posedge clk); #1;
        bus.inst_data_ok = 1'b0;
        @(negedge clk);
        chk("fl_after_pc", bus.if_pc, EXC_PC);
        chk("fl_after_inst", bus.if_inst, 32'h42000018);

        // Flush and data_ok together in WAIT
        @(posedge clk); #1;
        bus.inst_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.inst_addr_ok = 1'b0; bus.flush = 1'b1; bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'hcafef00d;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.inst_data_ok = 1'b0; bus.pc = EXC_PC;
        @(negedge clk);
        chk("flok_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("flok_req", {31'b0, bus.inst_req}, 32'd1);

        // Asynchronous reset in WAIT
        @(posedge clk); #1;
        bus.inst_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.inst_addr_ok = 1'b0;
        @(negedge clk); #2;
        rst = 1'b0; bus.flush = 1'b1;
        #1;
        chk("arst_req", {31'b0, bus.inst_req}, 32'd0);
        chk("arst_refresh", {31'b0, bus.pc_refresh}, 32'd0);
        chk("arst_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("arst_pc", bus.if_pc, RESET_PC);
        chk("arst_inst", bus.if_inst, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; bus.flush = 1'b0; bus.pc = RESET_PC; bus.inst_addr_ok = 1'b0;
        sb_en = 1'b1;
        @(negedge clk);
        chk("arst_first_req", {31'b0, bus.inst_req}, 32'd1);

        // Randomized run against the scoreboard
        pc_r = RESET_PC; refresh_seen = 0; flush_seen = 0; env_out = 0; env_lat = 0;
        env_addr = RESET_PC;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (refresh_seen) begin
                if (flush_seen)                  pc_r = EXC_PC;
                else if ($urandom_range(0, 9) == 0) pc_r = {pc_r[31:2], 2'b00} + 32'd6;
                else                             pc_r = {pc_r[31:2], 2'b00} + 32'd4;
            end
            bus.pc           = pc_r;
            bus.pc_adel      = |pc_r[1:0];
            bus.flush        = ($urandom_range(0, 19) == 0);
            bus.inst_addr_ok = ($urandom_range(0, 2) != 0);
            bus.id_allowin   = ($urandom_range(0, 3) != 0);
            bus.inst_data_ok = 1'b0;
            bus.inst_rdata   = $urandom;
            if (env_out) begin
                if (env_lat == 0) begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata   = mem_word(env_addr);
                    env_out          = 1'b0;
                end else begin
                    env_lat--;
                end
            end
            @(negedge clk); #1;
            busy  = env_out || bus.inst_data_ok;
            issue = bus.inst_req && bus.inst_addr_ok;
            fake  = bus.pc_refresh && !bus.flush && !issue;
            if (bus.inst_req) begin
                chk("req_while_busy", {31'b0, busy}, 32'd0);
                chk("req_addr", bus.inst_addr, bus.pc);
            end
            if (bus.flush) begin
                chk("flush_noreq", {31'b0, bus.inst_req}, 32'd0);
                chk("flush_refresh", {31'b0, bus.pc_refresh}, 32'd1);
                sb.delete();
            end
            if (issue) begin
                chk("issue_aligned", {31'b0, bus.pc_adel}, 32'd0);
                sb.push_back('{pc: bus.pc, inst: mem_word(bus.pc), adel: 1'b0});
                env_out  = 1'b1;
                env_addr = bus.pc;
                env_lat  = $urandom_range(0, 2);
            end
            if (fake) begin
                chk("fake_adel", {31'b0, bus.pc_adel}, 32'd1);
                chk("fake_idle", {31'b0, busy}, 32'd0);
                sb.push_back('{pc: bus.pc, inst: 32'h0, adel: 1'b1});
            end
            refresh_seen = bus.pc_refresh;
            flush_seen   = bus.flush;
        end
        sb_en = 1'b0;
        chk("progress", {31'b0, npop > 100}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
